// File: rtl/mbc_multi.sv
// Multi-game MBC5-style cartridge mapper: banked ROM/RAM decode plus a one-shot
// unlock sequence that commits a game slot and pulses the console reset.
module mbc_multi #(
  parameter int                ROM_BANK_W = 9,
  parameter int                RAM_BANK_W = 4,
  parameter int                SLOT_W     = 2,
  parameter logic [SLOT_W-1:0] MENU_SLOT  = '1,
  parameter int                TIMEOUT    = 65535,
  parameter int                RST_CYCLES = 1024
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [3:0]                   GB_A,
  input  logic [7:0]                   GB_D,
  input  logic                         GB_CS,
  input  logic                         GB_WR,
  input  logic                         GB_RD,
  output logic                         GB_RST,
  output logic [ROM_BANK_W+SLOT_W-1:0] ROM_A,
  output logic [RAM_BANK_W+SLOT_W-1:0] RAM_A,
  output logic                         ROM_CS,
  output logic                         RAM_CS,
  output logic                         DDIR,
  output logic                         LOCKED
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int PW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM1   = 2'd1,
    S_ARM2   = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [3:0]            a_s1, a_s2;
  logic [7:0]            d_s1, d_s2;
  logic                  wr_s1, wr_s2, wr_q;
  logic                  wr_acc, wr_7, lock_entry, tmo_hit;
  logic [ROM_BANK_W-1:0] rom_bank;
  logic [RAM_BANK_W-1:0] ram_bank;
  logic                  ram_en;
  logic [SLOT_W-1:0]     slot_q, slot_d, slot_eff;
  logic [TW-1:0]         tmo_q;
  logic [PW-1:0]         pcnt_q;
  logic                  pulse_pend_q, gb_rst_q;
  logic                  rom_win, rom_lower, ram_win;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_s1  <= '1;
      a_s2  <= '1;
      d_s1  <= '1;
      d_s2  <= '1;
      wr_s1 <= 1'b1;
      wr_s2 <= 1'b1;
      wr_q  <= 1'b1;
    end else begin
      a_s1  <= GB_A;
      a_s2  <= a_s1;
      d_s1  <= GB_D;
      d_s2  <= d_s1;
      wr_s1 <= GB_WR;
      wr_s2 <= wr_s1;
      wr_q  <= wr_s2;
    end
  end

  // Falling edge of the synchronized strobe: one accept per WR pulse.
  assign wr_acc  = ~wr_s2 & wr_q & gb_rst_q;
  assign wr_7    = wr_acc && (a_s2 == 4'h7);
  assign tmo_hit = (tmo_q >= TW'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    case (state_q)
      S_IDLE: begin
        if (wr_7 && d_s2 == 8'hA5) state_d = S_ARM1;
      end
      S_ARM1: begin
        if (wr_7)         state_d = (d_s2 == 8'h5A) ? S_ARM2 : S_IDLE;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_ARM2: begin
        if (wr_7) begin
          state_d = S_LOCKED;
          slot_d  = d_s2[SLOT_W-1:0];
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_LOCKED;
    endcase
  end

  assign lock_entry = (state_q != S_LOCKED) && (state_d == S_LOCKED);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      if ((state_q == S_ARM1 || state_q == S_ARM2) && state_d == state_q && !wr_7)
        tmo_q <= tmo_q + 1'b1;
      else
        tmo_q <= '0;
    end
  end

  // Reset pulse starts one clock after lock, so the bank reload lands first.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pulse_pend_q <= 1'b0;
      gb_rst_q     <= 1'b1;
      pcnt_q       <= '0;
    end else begin
      pulse_pend_q <= lock_entry;
      if (pulse_pend_q) begin
        gb_rst_q <= 1'b0;
        pcnt_q   <= PW'(RST_CYCLES - 1);
      end else if (!gb_rst_q) begin
        if (pcnt_q == '0) gb_rst_q <= 1'b1;
        else              pcnt_q   <= pcnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rom_bank <= ROM_BANK_W'(1);
      ram_bank <= '0;
      ram_en   <= 1'b0;
    end else if (lock_entry) begin
      rom_bank <= ROM_BANK_W'(1);
      ram_bank <= '0;
      ram_en   <= 1'b0;
    end else if (wr_acc) begin
      case (a_s2)
        4'h0, 4'h1: ram_en <= (d_s2[3:0] == 4'hA);
        4'h2:       rom_bank[7:0] <= d_s2;
        4'h3:       rom_bank[ROM_BANK_W-1:8] <= d_s2[ROM_BANK_W-9:0];
        4'h4, 4'h5: ram_bank <= d_s2[RAM_BANK_W-1:0];
        default:    ;
      endcase
    end
  end

  assign slot_eff  = (state_q == S_LOCKED) ? slot_q : MENU_SLOT;
  assign rom_win   = ~GB_A[3];
  assign rom_lower = (GB_A[3:2] == 2'b00);
  assign ram_win   = (GB_A[3:1] == 3'b101);

  assign ROM_A  = {slot_eff, rom_lower ? {ROM_BANK_W{1'b0}} : rom_bank};
  assign RAM_A  = {slot_eff, ram_bank};
  assign ROM_CS = ~(rom_win & gb_rst_q);
  assign RAM_CS = ~(ram_win & ram_en & ~GB_CS & gb_rst_q);
  assign DDIR   = (~ROM_CS | ~RAM_CS) & ~GB_RD;
  assign GB_RST = gb_rst_q;
  assign LOCKED = (state_q == S_LOCKED);

endmodule
